sat_addsub_pipe: RTL and testbench
==================================

# sat_addsub_pipe

Parametrised, pipelined saturating adder/subtractor: the segmented-pipeline successor to the datapath's 16-bit combinational add/sub. Operands are split into SEGS equal segments that ripple through SEGS register stages, one segment per stage. Each result is either saturated or wrapped, and carries N/Z/V/C flags. It sits in the execute stage behind a valid/ready handshake, so long-width ALU ops can be retimed without touching the callers.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SEGS.
- SEGS, 4, number of segments = pipeline stages; range 1..WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- sub  in  1  1: A-B, 0: A+B.
- sat_en  in  1  1: saturate on overflow; 0: wrap. Address/memory ops use 0.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  sum or difference.
- flag_n  out  1  result[WIDTH-1].
- flag_z  out  1  result == 0.
- flag_v  out  1  signed overflow of the raw operation, reported regardless of sat_en.
- flag_c  out  1  carry out of the MSB of the raw adder (for subtraction: 1 = no borrow).

## Operation
- Effective B: Beff = sub ? ~b : b. Carry-in to segment 0 = sub.
- Segment width: SW = WIDTH/SEGS.
- Stage s (1..SEGS):
  - adds segment s-1 of A and Beff with the carry from stage s-1;
  - registers the partial sum bits produced so far, the carry, the still-unused upper operand bits, and sub, sat_en, a[WIDTH-1] and Beff[WIDTH-1].
- Overflow, computed in the final stage from raw sum S:
  - V = (a[W-1] == Beff[W-1]) && (S[W-1] != a[W-1]).
- Result:
  - if V && sat_en: {a[W-1], {W-1{~a[W-1]}}}, i.e. 0x8000 or 0x7FFF for W=16;
  - else: S.
- flag_n and flag_z are computed on the final result, after saturation. flag_v and flag_c are raw.
- Each stage holds a valid bit; bubbles propagate and are not compressed.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance = 1, every stage shifts by one and stage 1 loads (in_valid & in_ready).
  - When advance = 0, all stages hold, including result and flags.
  - Inputs are ignored when in_ready = 0.
- Output stage:
  - out_valid is the valid bit of stage SEGS.
  - result and flags are held stable while out_valid & ~out_ready.
  - Values on result and flags when out_valid = 0 are don't-care, except after reset.

## Timing
- Reset (rst high at a rising edge):
  - all valid bits, out_valid, result and all flags go to 0;
  - in-flight operations are discarded, not completed;
  - in_ready is 1 in the first cycle after reset deasserts.
- Latency:
  - a beat accepted in cycle c (in_valid & in_ready high during c) appears with out_valid = 1 in cycle c+SEGS, provided there are no stalls;
  - SEGS=1 is a single output register, result in cycle c+1.
- Throughput: one op per cycle while out_ready = 1.
- Stalls: each cycle with out_valid & ~out_ready delays every in-flight beat by exactly one cycle. Ordering is preserved.
- Same-cycle pop and push: if out_valid & out_ready and in_valid in the same cycle, the output beat retires and the new beat enters stage 1 on the same edge.
- Pipeline full with out_ready = 0: in_ready = 0 combinationally from out_valid and out_ready; there is no other path from input to output.
- Carry crosses segment boundaries only through registers. There is no combinational carry path longer than SW bits.

## Test plan
All scenarios use W=16, SEGS=4, out_ready=1 and sat_en=1 unless stated.
- Basic add: 0x0005+0x0008 -> 0x000D, N=0 Z=0 V=0 C=0, out_valid exactly 4 cycles after accept.
- Add overflow:
  - 0x8000+0x8001 -> 0x8000, V=1 C=1;
  - 0x7000+0x7000 -> 0x7FFF, V=1, N=0.
- Subtract overflow:
  - 0x7FFF-0x8000 -> 0x7FFF, V=1;
  - repeated with sat_en=0 -> 0xFFFF, V=1 N=1;
  - 0x1234-0x1234 -> 0x0000, Z=1 C=1.
- Segment carry chain:
  - 0x0FFF+0x0001 -> 0x1000;
  - 0xFFFF+0x0001 (sat_en=0) -> 0x0000, Z=1 C=1 V=0.
- Backpressure: stream 8 back-to-back beats with out_ready low for 3 cycles mid-stream -> no beat lost or duplicated, order preserved, result stable during the stall, in_ready=0 while stalled with out_valid=1.
- Reset and parameters:
  - assert rst with 3 beats in flight -> out_valid=0 and result=0 the next cycle, no stale beat emerges afterward;
  - rerun scenario 1 with SEGS=1 (latency 1) and WIDTH=32, SEGS=8 with 0x7FFFFFFF+1 -> 0x7FFFFFFF, V=1.

Source files
------------

// File: rtl/sat_addsub_pipe.sv
// Segmented, pipelined saturating adder/subtractor with N/Z/V/C flags.
// One SW-bit segment is added per stage; carries cross segments only through registers.
module sat_addsub_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    localparam int unsigned SW = WIDTH / SEGS;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        // OW: operand bits not yet consumed; DW: sum bits complete after this stage
        localparam int unsigned OW = WIDTH - k * SW;
        localparam int unsigned DW = (k + 1) * SW;

        logic [OW-1:0] op_a;
        logic [OW-1:0] op_b;
        logic          cin;
        logic          sat;
        logic          vin;
        logic [SW:0]   seg;
        logic [DW-1:0] sum;

        if (k == 0) begin : g_src
            assign op_a = a;
            assign op_b = b_eff;
            assign cin  = sub;
            assign sat  = sat_en;
            assign vin  = in_valid;
            assign sum  = seg[SW-1:0];
        end else begin : g_src
            assign op_a = g_stage[k-1].g_reg.r_a;
            assign op_b = g_stage[k-1].g_reg.r_b;
            assign cin  = g_stage[k-1].g_reg.r_c;
            assign sat  = g_stage[k-1].g_reg.r_sat;
            assign vin  = g_stage[k-1].g_reg.r_valid;
            assign sum  = {seg[SW-1:0], g_stage[k-1].g_reg.r_sum};
        end

        assign seg = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + (SW + 1)'(cin);

        if (k < SEGS - 1) begin : g_reg
            logic [OW-SW-1:0] r_a;
            logic [OW-SW-1:0] r_b;
            logic [DW-1:0]    r_sum;
            logic             r_c;
            logic             r_sat;
            logic             r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_sum   <= '0;
                    r_c     <= 1'b0;
                    r_sat   <= 1'b0;
                end else if (advance) begin
                    r_valid <= vin;
                    r_a     <= op_a[OW-1:SW];
                    r_b     <= op_b[OW-1:SW];
                    r_sum   <= sum;
                    r_c     <= seg[SW];
                    r_sat   <= sat;
                end
            end
        end else begin : g_out
            logic             a_msb;
            logic             b_msb;
            logic             ovf;
            logic [WIDTH-1:0] res;

            // The top segment still carries both operand sign bits
            assign a_msb = op_a[SW-1];
            assign b_msb = op_b[SW-1];
            assign ovf   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
            assign res   = (ovf && sat) ? {a_msb, {(WIDTH-1){~a_msb}}} : sum;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                    flag_n    <= 1'b0;
                    flag_z    <= 1'b0;
                    flag_v    <= 1'b0;
                    flag_c    <= 1'b0;
                end else if (advance) begin
                    out_valid <= vin;
                    result    <= res;
                    flag_n    <= res[WIDTH-1];
                    flag_z    <= (res == '0);
                    flag_v    <= ovf;
                    flag_c    <= seg[SW];
                end
            end
        end
    end

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Self-checking bench for sat_addsub_pipe: vector table, scoreboard, backpressure,
// reset-in-flight and alternate parameter sets.
module tb_sat_addsub_pipe;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] res;
        logic [3:0]  nzvc;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  nzvc;
        bit          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT, W=16 SEGS=4
    logic        in_valid = 1'b0, in_ready, sub = 1'b0, sat_en = 1'b1;
    logic [15:0] a = '0, b = '0, result;
    logic        out_valid, out_ready = 1'b1, flag_n, flag_z, flag_v, flag_c;

    sat_addsub_pipe #(.WIDTH(16), .SEGS(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    // W=16 SEGS=1
    logic        iv1 = 1'b0, ir1, sub1 = 1'b0, sat1 = 1'b1, ov1, or1 = 1'b1;
    logic [15:0] a1 = '0, b1 = '0, r1;
    logic        n1, z1, v1, c1;

    sat_addsub_pipe #(.WIDTH(16), .SEGS(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .sub(sub1), .sat_en(sat1),
        .out_valid(ov1), .out_ready(or1), .result(r1),
        .flag_n(n1), .flag_z(z1), .flag_v(v1), .flag_c(c1)
    );

    // W=32 SEGS=8
    logic        iv32 = 1'b0, ir32, sub32 = 1'b0, sat32 = 1'b1, ov32, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, r32;
    logic        n32, z32, v32, c32;

    sat_addsub_pipe #(.WIDTH(32), .SEGS(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .sub(sub32), .sat_en(sat32),
        .out_valid(ov32), .out_ready(or32), .result(r32),
        .flag_n(n32), .flag_z(z32), .flag_v(v32), .flag_c(c32)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b0;
    exp_t drv_exp;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: signed/unsigned integer arithmetic
    function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y,
                                     input logic s, input logic sat);
        exp_t        e;
        int          r;
        bit          v;
        bit          c;
        logic [15:0] res;
        r   = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
        v   = (r > 32767) || (r < -32768);
        c   = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
        res = (v && sat) ? ((r > 0) ? 16'h7FFF : 16'h8000) : 16'(r);
        e.res  = res;
        e.nzvc = {res[15], res == 16'h0000, v, c};
        e.lat  = 1'b0;
        e.cyc  = 0;
        return e;
    endfunction

    // Scoreboard: pop on output handshake, push on input handshake, stall checks
    logic [19:0] held;
    bit          stall_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid)
                chk("stall_hold", {result, flag_n, flag_z, flag_v, flag_c}, held);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", result);
                end else begin
                    e = sbq.pop_front();
                    n_out++;
                    chk("result", result, e.res);
                    chk("flags_nzvc", {flag_n, flag_z, flag_v, flag_c}, e.nzvc);
                    if (e.lat) chk("latency", cyc - e.cyc, 4);
                end
            end
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            stall_prev = out_valid && !out_ready;
            held       = {result, flag_n, flag_z, flag_v, flag_c};
            if (in_valid && in_ready) begin
                e     = drv_exp;
                e.cyc = cyc;
                sbq.push_back(e);
            end
        end
    end

    // Drive one beat and hold it until accepted (called at posedge+1)
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic sat, input exp_t e);
        bit acc;
        int k;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        sat_en = sat;
        drv_exp = e;
        drv_exp.lat = chk_lat;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic run1(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [15:0] er, input logic [3:0] ef);
        int lat;
        iv1 = 1'b1; a1 = x; b1 = y; sub1 = s; sat1 = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("segs1_latency", lat, 1);
        chk("segs1_result", r1, er);
        chk("segs1_flags", {n1, z1, v1, c1}, ef);
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [31:0] er, input logic [3:0] ef);
        int lat;
        iv32 = 1'b1; a32 = x; b32 = y; sub32 = s; sat32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w32_latency", lat, 8);
        chk("w32_result", r32, er);
        chk("w32_flags", {n32, z32, v32, c32}, ef);
    endtask

    vec_t tbl[13];
    exp_t e0;

    initial begin
        tbl[0]  = '{16'h0005, 16'h0008, 1'b0, 1'b1, 16'h000D, 4'b0000};
        tbl[1]  = '{16'h8000, 16'h8001, 1'b0, 1'b1, 16'h8000, 4'b1011};
        tbl[2]  = '{16'h7000, 16'h7000, 1'b0, 1'b1, 16'h7FFF, 4'b0010};
        tbl[3]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 4'b0010};
        tbl[4]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 16'hFFFF, 4'b1010};
        tbl[5]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 4'b0101};
        tbl[6]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1000, 4'b0000};
        tbl[7]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0101};
        tbl[8]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1011};
        tbl[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 4'b1000};
        tbl[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b0111};
        tbl[11] = '{16'h00F0, 16'h0010, 1'b0, 1'b1, 16'h0100, 4'b0000};
        tbl[12] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1010};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {flag_n, flag_z, flag_v, flag_c}, 0);
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);

        // Isolated basic add with latency check
        chk_lat = 1'b1;
        e0.res = tbl[0].res; e0.nzvc = tbl[0].nzvc; e0.lat = 1'b0; e0.cyc = 0;
        send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].sat, e0);
        drain();

        // Whole table back-to-back
        for (int i = 0; i < 13; i++) begin
            e0.res = tbl[i].res; e0.nzvc = tbl[i].nzvc;
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat, e0);
        end
        drain();

        // Backpressure: 8 beats, out_ready low for 3 cycles mid-stream
        chk_lat = 1'b0;
        begin
            int base;
            base = n_out;
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        logic [15:0] x, y;
                        logic s, st;
                        x = 16'($urandom); y = 16'($urandom);
                        s = 1'($urandom); st = 1'($urandom);
                        send(x, y, s, st, model16(x, y, s, st));
                    end
                end
                begin
                    repeat (6) @(posedge clk);
                    #1 out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            join
            drain();
            chk("bp_beat_count", n_out - base, 8);
        end

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            e0.res = tbl[i].res; e0.nzvc = tbl[i].nzvc;
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat, e0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_flight_out_valid", out_valid, 0);
        chk("rst_flight_result", result, 0);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("rst_no_stale_beat", seen, 0);
        end

        // Alternate parameter sets
        run1(16'h0005, 16'h0008, 1'b0, 16'h000D, 4'b0000);
        run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0010);
        run32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
